icache_set_assoc: RTL

ICACHE_SET_ASSOC -- requirements
Module: icache_set_assoc

---
 rtl/icache_set_assoc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/icache_set_assoc.sv
// Set-associative, read-only instruction cache with tree-PLRU replacement.
// A miss fetches one 32-byte line from physical memory; the re-lookup after the fill then hits.
module icache_set_assoc #(
  parameter int WAYS = 2,
  parameter int SETS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic [31:0]  mem_address,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  input  logic         flush,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 27 - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
    $error("icache_set_assoc: WAYS must be 1, 2 or 4");
  end
  if (SETS < 2 || SETS > 256 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("icache_set_assoc: SETS must be a power of two in 2..256");
  end

  typedef enum logic {LOOKUP, FETCH} state_e;

  state_e            state_q;
  logic              flush_pending_q;
  logic [255:0]      line_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];

  // Tree bits point at the LRU side: bit0 selects the half, bit1/bit2 the way within it.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] cur,
                                                   input logic [WAY_W-1:0]  way);
    logic [2:0] t;
    int         w;
    t = 3'(cur);
    w = int'(way);
    if (WAYS == 2) begin
      t[0] = (w == 0);
    end else if (WAYS == 4) begin
      t[0] = (w < 2);
      if (w < 2) t[1] = (w == 0);
      else       t[2] = (w == 2);
    end
    return t[PLRU_W-1:0];
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [2:0] t;
    int         v;
    t = 3'(bits);
    v = 0;
    if (WAYS == 2)      v = int'(t[0]);
    else if (WAYS == 4) v = t[0] ? (t[2] ? 3 : 2) : (t[1] ? 1 : 0);
    return WAY_W'(v);
  endfunction

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic             unused_addr_bits;

  assign idx              = mem_address[5 +: IDX_W];
  assign tag              = mem_address[31 -: TAG_W];
  assign word             = mem_address[4:2];
  assign unused_addr_bits = ^mem_address[1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             found_invalid;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // An empty way always wins over the PLRU choice, lowest index first.
    victim_way    = plru_victim(plru_q[idx]);
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[idx][w] && !found_invalid) begin
        found_invalid = 1'b1;
        victim_way    = WAY_W'(w);
      end
    end
  end

  logic [255:0] hit_line;
  logic         fill_commit;

  assign hit_line    = line_q[idx][hit_way];
  assign mem_rdata   = hit_line[{word, 5'b0} +: 32];
  assign mem_resp    = (state_q == LOOKUP) && mem_read && hit && !flush;
  assign pmem_read   = (state_q == FETCH);
  assign fill_commit = (state_q == FETCH) && pmem_resp && !flush && !flush_pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LOOKUP;
      flush_pending_q <= 1'b0;
      pmem_address    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        LOOKUP: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              plru_q[s]  <= '0;
            end
          end else if (mem_read && hit) begin
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
          end else if (mem_read) begin
            pmem_address <= {mem_address[31:5], 5'b0};
            state_q      <= FETCH;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            state_q         <= LOOKUP;
            flush_pending_q <= 1'b0;
            // A flush seen at any point during the fill makes the returned line stale.
            if (flush || flush_pending_q) begin
              for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
              end
            end else begin
              valid_q[idx][victim_way] <= 1'b1;
              plru_q[idx]              <= plru_touch(plru_q[idx], victim_way);
            end
          end else if (flush) begin
            flush_pending_q <= 1'b1;
          end
        end
        default: state_q <= LOOKUP;
      endcase
    end
  end

  // Line and tag storage carry no reset; validity alone decides whether they are used.
  always_ff @(posedge clk) begin
    if (fill_commit) begin
      line_q[idx][victim_way] <= pmem_rdata;
      tag_q[idx][victim_way]  <= tag;
    end
  end

endmodule
